mem_access_stage: RTL

Memory-access (MEM) stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues loads and stores to data memory over a req/ack bus and aligns and extends load data. While an access is outstanding it stalls the upstream pipeline and injects a bubble into MEM/WB.

---
 rtl/mem_access_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing req/ack data-memory accesses and aligning/extending load data.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_access_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [4:0]  dest_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] store_val_in,
    input  logic [2:0]  funct3_in,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [4:0]  dest_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_read_val_out,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        misalign_trap
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_req;
    logic [31:0] r_rdata_q;
    logic        w_active, w_mis, w_trap, w_stall, w_req;
    logic [1:0]  w_off;
    logic [31:0] w_sh, w_hw, w_load, w_wdata;
    logic [3:0]  w_be;

    assign w_active = mem_r_en_in | mem_w_en_in;
    assign w_off    = alu_res_in[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = w_active & (funct3_in[1] ? |w_off : funct3_in[0] & w_off[0]);
`else
    assign w_mis = 1'b0;
`endif
    assign w_trap  = w_mis & (r_state == IDLE);
    assign w_stall = w_active & (r_state != DONE) & ~w_trap;

    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE && w_active && !w_mis) w_next = REQ;
        else if (r_state == REQ) w_next = dmem_ack ? DONE : REQ;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == REQ);
            if (r_state == REQ && dmem_ack) r_rdata_q <= dmem_rdata;
        end
    end

    // Load alignment: byte lane by full offset, halfword lane by addr[1] only
    assign w_sh   = r_rdata_q >> {w_off, 3'b000};
    assign w_hw   = r_rdata_q >> {alu_res_in[1], 4'b0000};
    assign w_load = funct3_in[1] ? r_rdata_q :
                    funct3_in[0] ? {{16{~funct3_in[2] & w_hw[15]}}, w_hw[15:0]} :
                                   {{24{~funct3_in[2] & w_sh[7]}}, w_sh[7:0]};

    assign w_be    = funct3_in[1] ? 4'b1111 :
                     funct3_in[0] ? (alu_res_in[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_off;
    assign w_wdata = funct3_in[1] ? store_val_in :
                     funct3_in[0] ? {2{store_val_in[15:0]}} : {4{store_val_in[7:0]}};

    // Every output is forced low while rstn is asserted
    assign w_req            = rstn & r_req;
    assign dmem_req         = w_req;
    assign dmem_we          = w_req & mem_w_en_in;
    assign dmem_be          = w_req ? w_be : 4'b0000;
    assign dmem_wdata       = w_req ? w_wdata : 32'd0;
    assign dmem_addr        = rstn ? {alu_res_in[31:2], 2'b00} : 32'd0;
    assign stall            = rstn & w_stall;
    assign misalign_trap    = rstn & w_trap;
    assign wb_en_out        = rstn & wb_en_in & ~(mem_r_en_in & mem_w_en_in) & ~w_stall & ~w_trap;
    assign mem_r_en_out     = rstn & mem_r_en_in & ~w_stall;
    assign dest_out         = rstn ? dest_in : 5'd0;
    assign alu_res_out      = rstn ? alu_res_in : 32'd0;
    assign mem_read_val_out = (rstn && w_active && r_state == DONE) ? w_load : 32'd0;
endmodule
